// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for one shared, externally pipelined multiplier.
// Latency: response valid LAT+2 cycles after the acceptance edge; one acceptance per cycle.
// Backpressure: a requester is stalled only by losing arbitration; responses cannot be stalled.
module mul_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [WIDTH-1:0]           req0_a,
    input  logic [WIDTH-1:0]           req0_b,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [WIDTH-1:0]           req1_a,
    input  logic [WIDTH-1:0]           req1_b,
    output logic                       req1_ready,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_result,
    output logic                       rsp0_valid,
    output logic [2*WIDTH-1:0]         rsp0_data,
    output logic                       rsp1_valid,
    output logic [2*WIDTH-1:0]         rsp1_data,
    output logic [$clog2(LAT+3)-1:0]   inflight
);
    localparam int IW = $clog2(LAT + 3);

    logic         last_grant;   // 1: requester 1 was granted most recently
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic         rsp_any;
    logic [LAT:0] tag_vld;      // stage k holds the tag of the product LAT-k cycles from mul_result
    logic [LAT:0] tag_id;       // requester id riding alongside tag_vld

    // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && !grant0;
    end

    // Nothing is accepted while reset is held.
    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;
    assign accept     = req0_ready || req1_ready;
    assign rsp_any    = rsp0_valid || rsp1_valid;

    // Last-grant register moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= req1_ready;
        end
    end

    // Operand registers feeding the shared multiplier; they hold between acceptances.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (req0_ready) begin
            mul_a <= req0_a;
            mul_b <= req0_b;
        end else if (req1_ready) begin
            mul_a <= req1_a;
            mul_b <= req1_b;
        end
    end

    // Tag pipeline shifts every cycle so stage LAT coincides with the matching mul_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[LAT-1:0], accept};
            tag_id  <= {tag_id[LAT-1:0], req1_ready};
        end
    end

    // Capture the product for the tagged requester and pulse its valid for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= tag_vld[LAT] && !tag_id[LAT];
            rsp1_valid <= tag_vld[LAT] &&  tag_id[LAT];
            if (tag_vld[LAT] && !tag_id[LAT]) begin
                rsp0_data <= mul_result;
            end
            if (tag_vld[LAT] && tag_id[LAT]) begin
                rsp1_data <= mul_result;
            end
        end
    end

    // Outstanding-request count: up on acceptance, down when a response is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (accept && !rsp_any) begin
            inflight <= inflight + IW'(1);
        end else if (!accept && rsp_any) begin
            inflight <= inflight - IW'(1);
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: external multiplier model, queue-based reference model, directed and random scenarios.
// Responses are expected LAT+2 cycles after acceptance, in acceptance order.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled on the falling edge.
module tb_mul_arbiter;
    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int IW  = $clog2(LAT + 3);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_result;
    logic           rsp0_valid, rsp1_valid;
    logic [2*W-1:0] rsp0_data, rsp1_data;
    logic [IW-1:0]  inflight;

    int n_tests = 0;
    int n_fail  = 0;

    mul_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Shared multiplier: product of the registered operands appears LAT cycles later; never reset.
    logic [2*W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) mpipe[k] <= mpipe[k-1];
        mpipe[0] <= prod(mul_a, mul_b);
    end
    assign mul_result = mpipe[LAT-1];

    // Reference model: list of accepted requests, each with the cycle its response is due.
    typedef struct {
        logic           id;
        logic [2*W-1:0] data;
        int             due;
    } rsp_t;
    rsp_t           q[$];
    int             cyc    = 0;
    bit             m_last = 1'b1;   // 1: requester 1 granted most recently
    bit             ev0 = 0, ev1 = 0;
    logic [2*W-1:0] ed0 = '0, ed1 = '0;
    int             exp_inf = 0;

    always @(posedge clk) begin
        bit g0, g1;
        cyc++;
        ev0 = 0;
        ev1 = 0;
        if (rst) begin
            q.delete();
            m_last = 1'b1;
            ed0 = '0;
            ed1 = '0;
        end else begin
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && !g0;
            if (g0 || g1) begin
                // accepted in cycle cyc-1, response due LAT+2 cycles later
                q.push_back('{id: g1, data: g1 ? prod(req1_a, req1_b) : prod(req0_a, req0_b),
                              due: cyc - 1 + LAT + 2});
                m_last = g1;
            end
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].id) begin ev1 = 1; ed1 = q[0].data; end
                else         begin ev0 = 1; ed0 = q[0].data; end
            end
        end
        exp_inf = q.size();
    end

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive(input logic r, input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        @(posedge clk);
        #1;
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, rand_op(), rand_op(), 1, rand_op(), rand_op());
            n_tests++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
            end
            n_tests++;
            if ({rsp0_valid, rsp1_valid, inflight, mul_a, mul_b, rsp0_data, rsp1_data} !== '0) begin
                n_fail++;
                $display("FAIL reset_state: vld=%b%b inflight=%0d mul_a=%h mul_b=%h d0=%h d1=%h want all 0",
                         rsp0_valid, rsp1_valid, inflight, mul_a, mul_b, rsp0_data, rsp1_data);
            end
        end
    endtask

    task automatic test_single();
        int acc;
        drive(0, 1, 3, 5, 0, '0, '0);
        acc = cyc;
        n_tests++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        for (int k = 1; k <= LAT + 4; k++) begin
            idle(1);
            n_tests++;
            if (rsp0_valid !== (cyc == acc + LAT + 2) || rsp1_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_valid: cycle +%0d got %b%b want %b0", k, rsp0_valid, rsp1_valid,
                         cyc == acc + LAT + 2);
            end
            if (cyc == acc + LAT + 2) begin
                n_tests++;
                if (rsp0_data !== 64'd15) begin n_fail++; $display("FAIL single_data: got %0d want 15", rsp0_data); end
            end
            n_tests++;
            if (inflight !== IW'((cyc <= acc + LAT + 2) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL single_inflight: cycle +%0d got %0d want %0d", k, inflight,
                         (cyc <= acc + LAT + 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_contention();
        int c0, k;
        logic [2*W-1:0] want;
        drive(1, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 8 + LAT + 3; i++) begin
            if (i < 8) drive(0, 1, W'(i), 2, 1, W'(100 + i), 2);
            else       idle(1);
            if (i == 0) c0 = cyc;
            if (i < 8) begin
                n_tests++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL contention_grant: i=%0d got %b%b want %b%b", i, req0_ready, req1_ready,
                             i % 2 == 0, i % 2 == 1);
                end
            end
            k = cyc - (c0 + LAT + 2);
            if (k >= 0 && k < 8) begin
                want = (k % 2 == 0) ? 2 * k : 200 + 2 * k;
                n_tests++;
                if (rsp0_valid !== (k % 2 == 0) || rsp1_valid !== (k % 2 == 1) ||
                    ((k % 2 == 0) ? rsp0_data : rsp1_data) !== want) begin
                    n_fail++;
                    $display("FAIL contention_rsp: k=%0d got vld=%b%b d0=%0d d1=%0d want data %0d", k,
                             rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, want);
                end
            end
        end
    endtask

    task automatic test_streaming();
        int c0, mx;
        mx = 0;
        idle(LAT + 4);
        for (int i = 0; i < 8 + LAT + 4; i++) begin
            if (i < 8) drive(0, 0, '0, '0, 1, '1, '1);
            else       idle(1);
            if (i == 0) c0 = cyc;
            if (int'(inflight) > mx) mx = int'(inflight);
            if (i < 8) begin
                n_tests++;
                if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: i=%0d got %b want 1", i, req1_ready); end
            end
            if (cyc >= c0 + LAT + 2 && cyc < c0 + LAT + 10) begin
                n_tests++;
                if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_data !== 64'hFFFFFFFE00000001) begin
                    n_fail++;
                    $display("FAIL stream_rsp: i=%0d got vld=%b%b d1=%h want 01 fffffffe00000001", i,
                             rsp0_valid, rsp1_valid, rsp1_data);
                end
            end
        end
        n_tests++;
        if (mx !== LAT + 2) begin n_fail++; $display("FAIL stream_peak: got %0d want %0d", mx, LAT + 2); end
    endtask

    task automatic test_flush();
        idle(LAT + 4);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, rand_op(), rand_op(), 0, '0, '0);
            n_tests++;
            if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept: i=%0d got %b want 1", i, req0_ready); end
        end
        idle(2);
        drive(1, 1, 7, 7, 0, '0, '0);
        n_tests++;
        if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready_in_rst: got %b want 0", req0_ready); end
        for (int i = 0; i < LAT + 8; i++) begin
            idle(1);
            n_tests++;
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || inflight !== '0) begin
                n_fail++;
                $display("FAIL flush_quiet: i=%0d got vld=%b%b inflight=%0d want 00 0", i, rsp0_valid,
                         rsp1_valid, inflight);
            end
        end
    endtask

    task automatic test_idle_gaps();
        int t0;
        idle(LAT + 4);
        drive(0, 1, rand_op(), 0, 0, '0, '0);
        t0 = cyc;
        n_tests++;
        if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL gap_first: got %b want 1", req0_ready); end
        idle(2);
        drive(0, 0, '0, '0, 1, rand_op(), 0);
        n_tests++;
        if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL gap_second: got %b want 1", req1_ready); end
        // last grant is now requester 1, so requester 0 must win this contention
        drive(0, 1, 9, 9, 1, 9, 9);
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL gap_last_grant: got %b%b want 10", req0_ready, req1_ready);
        end
        while (cyc < t0 + LAT + 5) begin
            idle(1);
            if (cyc >= t0 + LAT + 2) begin
                n_tests++;
                if (rsp0_valid !== (cyc == t0 + LAT + 2) || rsp1_valid !== (cyc == t0 + LAT + 5) ||
                    (rsp0_valid && rsp0_data !== '0) || (rsp1_valid && rsp1_data !== '0)) begin
                    n_fail++;
                    $display("FAIL gap_rsp: cycle t0+%0d got vld=%b%b d0=%h d1=%h", cyc - t0, rsp0_valid,
                             rsp1_valid, rsp0_data, rsp1_data);
                end
            end
        end
    endtask

    task automatic test_random();
        logic e0, e1;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, 1'($urandom), rand_op(), rand_op(),
                  1'($urandom), rand_op(), rand_op());
            e0 = !rst && req0_valid && (!req1_valid || m_last);
            e1 = !rst && req1_valid && !(req0_valid && (!req1_valid || m_last));
            n_tests++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                n_fail++; $display("FAIL rand_ready: i=%0d got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1);
            end
            n_tests++;
            if (rsp0_valid !== ev0 || rsp1_valid !== ev1 || rsp0_data !== ed0 || rsp1_data !== ed1) begin
                n_fail++;
                $display("FAIL rand_rsp: i=%0d got %b%b %h %h want %b%b %h %h", i, rsp0_valid, rsp1_valid,
                         rsp0_data, rsp1_data, ev0, ev1, ed0, ed1);
            end
            n_tests++;
            if (int'(inflight) !== exp_inf || int'(inflight) > LAT + 2) begin
                n_fail++; $display("FAIL rand_inflight: i=%0d got %0d want %0d", i, inflight, exp_inf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_streaming();
        test_flush();
        test_idle_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the product is 2*WIDTH bits.
REQ-002 The block SHALL have parameter LAT, default 4, giving the shared multiplier latency in cycles from operands presented to mul_result valid (LAT >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operand pair.
REQ-006 The block SHALL have ports req0_a and req0_b, input, WIDTH bits each: requester 0 operands.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 pair accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_a, req1_b and req1_ready, with the same widths and meanings as REQ-005 to REQ-007, for requester 1.
REQ-009 The block SHALL have ports mul_a and mul_b, output, WIDTH bits each: registered operands to the shared multiplier.
REQ-010 The block SHALL have port mul_result, input, 2*WIDTH bits: product from the shared multiplier.
REQ-011 The block SHALL have ports rsp0_valid, output, 1 bit, and rsp0_data, output, 2*WIDTH bits: result return to requester 0.
REQ-012 The block SHALL have ports rsp1_valid, output, 1 bit, and rsp1_data, output, 2*WIDTH bits: result return to requester 1.
REQ-013 The block SHALL have port inflight, output, $clog2(LAT+3) bits: number of accepted requests not yet returned.

Function
REQ-014 At most one request SHALL be accepted per cycle; reqN_ready SHALL be combinational from the reqN_valid inputs and the last-grant register, and SHALL never be high while reqN_valid is low.
REQ-015 Arbitration SHALL be round-robin: when only one request is valid, that requester is granted; when both are valid, the requester not granted most recently wins.
REQ-016 The last-grant register SHALL update only on a cycle with an accepted request.
REQ-017 On the acceptance edge, mul_a and mul_b SHALL load the granted operands; on cycles with no acceptance they SHALL hold their previous value.
REQ-018 The block SHALL keep a tag pipeline of LAT+1 stages carrying {valid, requester id}, shifting every cycle, so each tag reaches the output stage in the cycle in which mul_result holds the matching product.
REQ-019 When the output-stage tag is valid, the block SHALL register mul_result into rspN_data of the tagged requester and pulse that rspN_valid for exactly one cycle.
REQ-020 The latency from the acceptance edge (cycle N) to rspN_valid high SHALL be LAT+2 cycles, i.e. rspN_valid is high in cycle N+LAT+2.
REQ-021 Throughput SHALL be one request per cycle with no bubbles; responses SHALL return in acceptance order.
REQ-022 Responses SHALL have no backpressure: rsp0_valid and rsp1_valid are never high in the same cycle.
REQ-023 rspN_data SHALL hold its last value when rspN_valid is low.
REQ-024 inflight SHALL increment on acceptance, decrement on any rsp valid, and be unchanged when both occur in the same cycle.
REQ-025 inflight SHALL never exceed LAT+2.
REQ-026 The operand values themselves SHALL not affect arbitration, including all-zero and all-ones operands.

Reset
REQ-027 While rst is high: mul_a, mul_b, rsp0_data, rsp1_data and inflight SHALL be 0; rsp0_valid and rsp1_valid SHALL be 0; all tag-pipeline stages SHALL be invalid; last-grant SHALL be set to requester 1, so requester 0 wins the first contention.
REQ-028 While rst is high, req0_ready and req1_ready SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL flush all in-flight tags: no rspN_valid for requests accepted before reset, even if the multiplier later produces their products.

Verification
REQ-030 Single request with LAT=4: req0 with a=3, b=5 accepted in cycle 10 -> rsp0_valid high only in cycle 16 with rsp0_data=15; inflight goes 1 then back to 0.
REQ-031 Contention after reset: both requesters valid continuously, req0 a=i, req1 a=100+i, b=2 -> grants alternate 0,1,0,1 starting with req0; responses alternate with data 2i and 200+2i, one per cycle with no gaps.
REQ-032 Streaming: req1 alone valid for 8 consecutive cycles with a=0xFFFFFFFF, b=0xFFFFFFFF -> 8 consecutive rsp1_valid pulses, each 0xFFFFFFFE00000001; inflight peaks at 6.
REQ-033 Reset flush: 3 requests accepted, then rst high for 1 cycle two cycles later -> no rsp valid ever for those requests; inflight is 0 after reset.
REQ-034 Idle gaps: req0 valid, then 2 idle cycles, then req1 valid, both with b=0 -> responses with data 0, separated by 2 idle cycles; last-grant moves to requester 1 only after the second acceptance.
